uart_rx_fifo: RTL and testbench

Receive buffer placed between the uart_rx byte deserializer and the CPU-bus I/O peripheral, in the sysclk domain.
- Replaces the single-byte overwrite buffer with a DEPTH-entry first-word-fall-through FIFO.
- Adds sticky overrun and break flags, and an almost-full output the peripheral can use for RTS flow control.
- The bus side pops bytes and reads status; the UART side pushes on every valid strobe.

---
 rtl/h80_uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/h80_uart_pkg.sv
// rtl/h80_uart_pkg.sv - shared UART peripheral register map and status bit positions
//
// Purpose: constants shared between the receive FIFO and the CPU-bus UART
//          I/O peripheral that decodes the register map.
// Contents:
//   STAT_*      bit positions inside the UART_STATUS register
//   UART_*      register address offsets
//   CTRL_*      bit positions inside the UART_CTRL register

package h80_uart_pkg;

    // UART_STATUS bit positions
    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_RX_OVERRUN = 2;
    localparam int STAT_RX_BREAK   = 3;
    localparam int STAT_TX_BUSY    = 4;

    // Register address offsets
    localparam logic [1:0] UART_DATA   = 2'h0;
    localparam logic [1:0] UART_STATUS = 2'h1;
    localparam logic [1:0] UART_CTRL   = 2'h2;

    // UART_CTRL bit positions: bit0 drives flush, bit1 drives clr_flags
    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_FLAGS = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with sticky overrun/break flags
//
// Purpose: buffers bytes from the uart_rx deserializer for the bus-side
//          peripheral. Head entry is visible on rd_data whenever rd_valid=1.
// Ports:
//   clk, resetn          sysclk and synchronous active-low reset
//   wr_valid/wr_data     push strobe and byte from uart_rx
//   wr_break             break strobe from uart_rx (sets brk, never pushes)
//   rd_pop               pop strobe from the bus side
//   flush                discard all contents (flags kept)
//   clr_flags            clear overrun and brk
//   rd_data/rd_valid     head entry and not-empty
//   full/almost_full     count decodes (almost_full usable for RTS)
//   count                stored entries, 0..DEPTH
//   overrun/brk          sticky status flags

module uart_rx_fifo
    import h80_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_break,
    input  logic                       rd_pop,
    input  logic                       flush,
    input  logic                       clr_flags,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun,
    output logic                       brk
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
        end
        if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
            $error("uart_rx_fifo: AFULL_MARGIN must be in 1..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          brk_q, brk_d;

    logic empty;
    logic is_full;
    logic pop_ok;
    logic wr_req;
    logic push_ok;
    logic overflow;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == CW'(DEPTH));

    // A break cycle never carries data, so it masks the push request.
    // Flush overrides both sides, including the overflow that a push into a
    // full FIFO would otherwise report.
    assign pop_ok   = rd_pop && !empty && !flush;
    assign wr_req   = wr_valid && !wr_break && !flush;
    assign push_ok  = wr_req && (!is_full || pop_ok);
    assign overflow = wr_req && is_full && !pop_ok;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        brk_d     = brk_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
        end

        // Set events win over a same-cycle clear.
        if (clr_flags) begin
            overrun_d = 1'b0;
            brk_d     = 1'b0;
        end
        if (overflow) begin
            overrun_d = 1'b1;
        end
        if (wr_break) begin
            brk_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            brk_q     <= brk_d;
        end
    end

    // Storage is not reset; a stale entry is only visible when rd_valid=0.
    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign rd_valid    = !empty;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(DEPTH - AFULL_MARGIN));
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign brk         = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_break;
    logic          rd_pop;
    logic          flush;
    logic          clr_flags;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          almost_full;
    logic [4:0]    count;
    logic          overrun;
    logic          brk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored bytes plus the two sticky flags.
    logic [DW-1:0] mq [$];
    bit            m_ovr;
    bit            m_brk;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_break    (wr_break),
        .rd_pop      (rd_pop),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun),
        .brk         (brk)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit wv, input logic [DW-1:0] wd, input bit wb,
                              input bit pop, input bit fl, input bit clr, input bit rs);
        bit pop_ok;
        bit ovf;
        ovf = 0;
        if (!rs) begin
            mq.delete();
            m_ovr = 0;
            m_brk = 0;
            return;
        end
        pop_ok = pop && (mq.size() > 0);
        if (fl) begin
            mq.delete();
        end else if (wv && !wb) begin
            if (mq.size() < DEPTH || pop_ok) begin
                if (pop_ok) void'(mq.pop_front());
                mq.push_back(wd);
            end else begin
                ovf = 1;
            end
        end else if (pop_ok) begin
            void'(mq.pop_front());
        end
        m_ovr = (m_ovr && !clr) || ovf;
        m_brk = (m_brk && !clr) || wb;
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("count", int'(count), n);
        check("rd_valid", int'(rd_valid), int'(n > 0));
        check("full", int'(full), int'(n == DEPTH));
        check("almost_full", int'(almost_full), int'(n >= DEPTH - AFM));
        check("overrun", int'(overrun), int'(m_ovr));
        check("brk", int'(brk), int'(m_brk));
        if (n > 0) check("rd_data", int'(rd_data), int'(mq[0]));
    endtask

    task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit wb,
                       input bit pop, input bit fl, input bit clr, input bit rs);
        @(negedge clk);
        wr_valid  = wv;
        wr_data   = wd;
        wr_break  = wb;
        rd_pop    = pop;
        flush     = fl;
        clr_flags = clr;
        resetn    = rs;
        @(posedge clk);
        model_step(wv, wd, wb, pop, fl, clr, rs);
        #1;
        check_all();
    endtask

    task automatic push(input logic [DW-1:0] d);
        cyc(1, d, 0, 0, 0, 0, 1);
    endtask

    task automatic pop1();
        cyc(0, '0, 0, 1, 0, 0, 1);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0, 0, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 2 * DEPTH) begin
            pop1();
            guard++;
        end
        check("drain_empty", int'(rd_valid), 0);
    endtask

    initial begin
        resetn = 0; wr_valid = 0; wr_data = '0; wr_break = 0;
        rd_pop = 0; flush = 0; clr_flags = 0;

        cyc(0, '0, 0, 0, 0, 0, 0);
        idle();

        // Three-byte fall-through and ordered readback
        push(8'h41); push(8'h42); push(8'h43);
        check("three_count", int'(count), 3);
        drain();
        idle();

        // Fill, overflow with 'hFF, then drain 'h00..'h0F
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        push(8'hFF);
        check("ovf_overrun", int'(overrun), 1);
        check("ovf_count", int'(count), DEPTH);
        drain();
        cyc(0, '0, 0, 0, 0, 1, 1);

        // Full FIFO, push 'hAA with pop together
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        cyc(1, 8'hAA, 0, 1, 0, 0, 1);
        check("fullpp_count", int'(count), DEPTH);
        check("fullpp_overrun", int'(overrun), 0);
        for (int i = 0; i < DEPTH - 1; i++) pop1();
        check("last_is_aa", int'(rd_data), 'hAA);
        pop1();

        // Empty FIFO: push 'h55 with pop together, then pop-while-empty
        cyc(1, 8'h55, 0, 1, 0, 0, 1);
        check("emptypp_data", int'(rd_data), 'h55);
        pop1();
        pop1();
        check("empty_pop_count", int'(count), 0);

        // almost_full boundary at 12/11
        for (int i = 0; i < 12; i++) push(8'($urandom));
        check("afull_12", int'(almost_full), 1);
        pop1();
        check("afull_11", int'(almost_full), 0);
        drain();

        // 40 bytes with interleaved pops, wrapping the pointers
        for (int i = 0; i < 40; i++) cyc(1, 8'(8'h80 + i), 0, (i % 3) != 0, 0, 0, 1);
        drain();

        // Break with clear in the same cycle, then lone clear
        cyc(0, '0, 1, 0, 0, 1, 1);
        check("brk_set_wins", int'(brk), 1);
        cyc(0, '0, 0, 0, 0, 1, 1);
        check("brk_cleared", int'(brk), 0);

        // Flush at count 5 with overrun set
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        for (int i = 0; i < DEPTH - 5; i++) pop1();
        cyc(0, '0, 0, 0, 1, 0, 1);
        check("flush_count", int'(count), 0);
        check("flush_overrun", int'(overrun), 1);

        // Reset mid-stream
        push(8'h11); push(8'h22); cyc(0, '0, 1, 0, 0, 0, 1);
        cyc(1, 8'h33, 0, 0, 0, 0, 0);
        check("rst_count", int'(count), 0);
        check("rst_brk", int'(brk), 0);
        check("rst_overrun", int'(overrun), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit wv, wb, pop, fl, clr, rs;
            wv  = ($urandom_range(99) < 55);
            pop = ($urandom_range(99) < 45);
            wb  = ($urandom_range(99) < 3);
            clr = ($urandom_range(99) < 4);
            fl  = ($urandom_range(99) < 2);
            rs  = ($urandom_range(999) >= 3);
            if (fl) begin
                wv = 0; wb = 0; clr = 0;
            end
            cyc(wv, 8'($urandom), wb, pop, fl, clr, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
